instr_decode_stage: RTL and testbench

- Registered decode stage between instruction fetch and the immediate generator / register file.
- Accepts a fetched 32-bit RISC-V RV32I instruction and PC over a valid/ready handshake.
- Classifies the opcode into the immediate-format code used by the immediate generator, and splits out register/function fields.
- Presents the result one cycle later through a 2-entry skid buffer, so the upstream ready is a pure register output.

---
 rtl/instr_decode_stage_pkg.sv | 84 ++++++++
 rtl/decode_skid_buf.sv | 99 +++++++++
 rtl/decode_skid_buf_chk.sv | 24 ++
 rtl/instr_decode_stage.sv | 102 ++++++++++
 tb/tb_instr_decode_stage.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_decode_stage_pkg.sv
// -----------------------------------------------------------------------------
// instr_decode_stage_pkg
// Shared definitions for the RV32I decode stage and the immediate generator:
//   - imm_type_e    : immediate-format codes (I/B/S/U/J/none)
//   - OPC_*         : RV32I major opcodes
//   - decoded_t     : decoded instruction bundle (everything except the PC)
//   - classify_imm_type / opcode_is_known : opcode classification helpers
// -----------------------------------------------------------------------------
package instr_decode_stage_pkg;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_B    = 3'd1,
        IMM_S    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd7
    } imm_type_e;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [24:0] imm_in;
        imm_type_e   imm_type;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        funct7_5;
        logic        illegal;
    } decoded_t;

    // Bundle contents after reset: all zero, no immediate format.
    localparam decoded_t DECODED_RESET = '{
        imm_in:   25'd0,
        imm_type: IMM_NONE,
        opcode:   7'd0,
        rd:       5'd0,
        rs1:      5'd0,
        rs2:      5'd0,
        funct3:   3'd0,
        funct7_5: 1'b0,
        illegal:  1'b0
    };

    // Map a major opcode onto the immediate format it uses.
    function automatic imm_type_e classify_imm_type(input logic [6:0] opcode);
        imm_type_e t;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR,
            OPC_MISC_MEM, OPC_SYSTEM: t = IMM_I;
            OPC_STORE:                t = IMM_S;
            OPC_BRANCH:               t = IMM_B;
            OPC_LUI, OPC_AUIPC:       t = IMM_U;
            OPC_JAL:                  t = IMM_J;
            default:                  t = IMM_NONE; // R-type and unknown opcodes
        endcase
        return t;
    endfunction

    // True for every opcode the stage recognises (all formats plus R-type).
    function automatic logic opcode_is_known(input logic [6:0] opcode);
        logic k;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM,
            OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL,
            OPC_OP:   k = 1'b1;
            default:  k = 1'b0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/decode_skid_buf.sv
// -----------------------------------------------------------------------------
// decode_skid_buf
// Generic 2-entry skid buffer (main + skid register). in_ready is a flop so
// the upstream ready path has no combinational dependence on out_ready.
// Parameters: W (payload width), RESET_VAL (payload contents after reset).
// Ports:
//   clk, rst_n       clock, async active-low reset
//   flush            synchronous kill of both entries (drops a same-cycle accept)
//   in_valid/in_ready/in_data     upstream handshake
//   out_valid/out_ready/out_data  downstream handshake, driven from main entry
// -----------------------------------------------------------------------------
module decode_skid_buf #(
    parameter int           W         = 8,
    parameter logic [W-1:0] RESET_VAL = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid_r, main_valid_s;
    logic         skid_valid_r, skid_valid_s;
    logic         in_ready_r,   in_ready_s;
    logic [W-1:0] main_data_r,  main_data_s;
    logic [W-1:0] skid_data_r,  skid_data_s;
    logic         accept_s;
    logic         fire_s;

    assign accept_s = in_valid & in_ready_r;
    assign fire_s   = main_valid_r & out_ready;

    // Next-state for both entries; data of an emptied entry holds its value.
    always_comb begin
        main_valid_s = main_valid_r;
        skid_valid_s = skid_valid_r;
        main_data_s  = main_data_r;
        skid_data_s  = skid_data_r;
        if (flush) begin
            main_valid_s = 1'b0;
            skid_valid_s = 1'b0;
        end else if (!main_valid_r || fire_s) begin
            if (skid_valid_r) begin
                // in_ready is low here, so no accept can collide with the refill
                main_data_s  = skid_data_r;
                main_valid_s = 1'b1;
                skid_valid_s = 1'b0;
            end else if (accept_s) begin
                main_data_s  = in_data;
                main_valid_s = 1'b1;
            end else begin
                main_valid_s = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_data_s  = in_data;
                skid_valid_s = 1'b1;
            end else begin
                skid_valid_s = skid_valid_r;
            end
        end
        in_ready_s = ~skid_valid_s;
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
            main_data_r  <= RESET_VAL;
            skid_data_r  <= RESET_VAL;
        end else begin
            main_valid_r <= main_valid_s;
            skid_valid_r <= skid_valid_s;
            in_ready_r   <= in_ready_s;
            main_data_r  <= main_data_s;
            skid_data_r  <= skid_data_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = main_valid_r;
    assign out_data  = main_data_r;

    decode_skid_buf_chk u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .main_valid (main_valid_r),
        .skid_valid (skid_valid_r),
        .in_ready   (in_ready_r)
    );

endmodule

// File: rtl/decode_skid_buf_chk.sv
// -----------------------------------------------------------------------------
// decode_skid_buf_chk
// Structural invariants of the 2-entry skid buffer.
// Ports: clk, rst_n, main_valid, skid_valid, in_ready (all observed only).
// -----------------------------------------------------------------------------
module decode_skid_buf_chk (
    input logic clk,
    input logic rst_n,
    input logic main_valid,
    input logic skid_valid,
    input logic in_ready
);

    // The skid entry only ever fills behind an occupied main entry.
    a_no_skid_without_main: assert property (
        @(posedge clk) disable iff (!rst_n) (main_valid || !skid_valid)
    );

    // Upstream ready is exactly "skid slot free".
    a_ready_tracks_skid: assert property (
        @(posedge clk) disable iff (!rst_n) (in_ready == !skid_valid)
    );

endmodule

// File: rtl/instr_decode_stage.sv
// -----------------------------------------------------------------------------
// instr_decode_stage
// Registered RV32I decode stage: classifies the opcode into the immediate
// format code, splits out register/function fields, and presents the result
// one cycle later through a 2-entry skid buffer.
// Optional feature: define DECODE_ILLEGAL_DETECT_EN to flag unrecognised
// opcodes on illegal_o; otherwise illegal_o is tied low.
// Parameters: XLEN (PC width), RESET_PC_TAG (pc_o after reset).
// Ports:
//   clk, rst_n, flush                       clock, async reset, redirect kill
//   in_valid, in_ready, instr_i, pc_i       fetch side
//   out_valid, out_ready                    downstream handshake
//   imm_in_o, imm_type_o, opcode_o, rd_o, rs1_o, rs2_o, funct3_o,
//   funct7_5_o, pc_o, illegal_o             decoded bundle
// -----------------------------------------------------------------------------
module instr_decode_stage
    import instr_decode_stage_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC_TAG = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [24:0]     imm_in_o,
    output logic [2:0]      imm_type_o,
    output logic [6:0]      opcode_o,
    output logic [4:0]      rd_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [2:0]      funct3_o,
    output logic            funct7_5_o,
    output logic [XLEN-1:0] pc_o,
    output logic            illegal_o
);

    localparam int DEC_W = $bits(decoded_t);
    localparam int BUF_W = XLEN + DEC_W;

    decoded_t           dec_s;
    decoded_t           out_dec_s;
    logic [BUF_W-1:0]   out_data_s;
    logic               out_valid_s;

    // Field split and opcode classification of the incoming instruction.
    always_comb begin
        dec_s          = DECODED_RESET;
        dec_s.imm_in   = instr_i[31:7];
        dec_s.imm_type = classify_imm_type(instr_i[6:0]);
        dec_s.opcode   = instr_i[6:0];
        dec_s.rd       = instr_i[11:7];
        dec_s.rs1      = instr_i[19:15];
        dec_s.rs2      = instr_i[24:20];
        dec_s.funct3   = instr_i[14:12];
        dec_s.funct7_5 = instr_i[30];
`ifdef DECODE_ILLEGAL_DETECT_EN
        dec_s.illegal  = ~opcode_is_known(instr_i[6:0]) | (instr_i[1:0] != 2'b11);
`else
        dec_s.illegal  = 1'b0;
`endif
    end

    decode_skid_buf #(
        .W         (BUF_W),
        .RESET_VAL ({RESET_PC_TAG, DECODED_RESET})
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({pc_i, dec_s}),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .out_data  (out_data_s)
    );

    assign out_dec_s  = out_data_s[DEC_W-1:0];
    assign pc_o       = out_data_s[BUF_W-1 -: XLEN];
    assign out_valid  = out_valid_s;
    assign imm_in_o   = out_dec_s.imm_in;
    // A stale entry must never be mistaken for a live immediate format.
    assign imm_type_o = out_valid_s ? out_dec_s.imm_type : IMM_NONE;
    assign opcode_o   = out_dec_s.opcode;
    assign rd_o       = out_dec_s.rd;
    assign rs1_o      = out_dec_s.rs1;
    assign rs2_o      = out_dec_s.rs2;
    assign funct3_o   = out_dec_s.funct3;
    assign funct7_5_o = out_dec_s.funct7_5;
`ifdef DECODE_ILLEGAL_DETECT_EN
    assign illegal_o  = out_dec_s.illegal;
`else
    assign illegal_o  = 1'b0;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_instr_decode_stage
// Scoreboard bench: each accepted instruction is pushed with its PC, and each
// downstream fire pops the oldest entry and compares all decoded fields against
// a reference decode written independently here.
// -----------------------------------------------------------------------------
module tb_instr_decode_stage;

    localparam logic [31:0] TAG = 32'hFFFF_F000;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr_i, pc_i, pc_o;
    logic [24:0] imm_in_o;
    logic [2:0]  imm_type_o, funct3_o;
    logic [6:0]  opcode_o;
    logic [4:0]  rd_o, rs1_o, rs2_o;
    logic        funct7_5_o, illegal_o;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int n_checks = 0;
    int n_errors = 0;
    bit last_accept;

    instr_decode_stage #(.XLEN(32), .RESET_PC_TAG(TAG)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr_i(instr_i), .pc_i(pc_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .imm_in_o(imm_in_o), .imm_type_o(imm_type_o), .opcode_o(opcode_o),
        .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .funct3_o(funct3_o),
        .funct7_5_o(funct7_5_o), .pc_o(pc_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [2:0] ref_imm_type(input logic [6:0] op);
        case (op)
            7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: return 3'd0;
            7'h63:                             return 3'd1;
            7'h23:                             return 3'd2;
            7'h37, 7'h17:                      return 3'd3;
            7'h6F:                             return 3'd4;
            default:                           return 3'd7;
        endcase
    endfunction

    function automatic logic ref_illegal(input logic [6:0] op);
`ifdef DECODE_ILLEGAL_DETECT_EN
        case (op)
            7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h63, 7'h23,
            7'h37, 7'h17, 7'h6F, 7'h33: return 1'b0;
            default:                    return 1'b1;
        endcase
`else
        return 1'b0;
`endif
    endfunction

    // One clock: score the cycle's handshakes at the falling edge, then advance.
    task automatic step();
        sb_entry_t e;
        @(negedge clk);
        last_accept = 1'b0;
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_pc",      pc_o,       e.pc);
                check("sb_imm_in",  imm_in_o,   e.instr[31:7]);
                check("sb_imm_type", imm_type_o, ref_imm_type(e.instr[6:0]));
                check("sb_opcode",  opcode_o,   e.instr[6:0]);
                check("sb_rd",      rd_o,       e.instr[11:7]);
                check("sb_rs1",     rs1_o,      e.instr[19:15]);
                check("sb_rs2",     rs2_o,      e.instr[24:20]);
                check("sb_funct3",  funct3_o,   e.instr[14:12]);
                check("sb_f7_5",    funct7_5_o, e.instr[30]);
                check("sb_illegal", illegal_o,  ref_illegal(e.instr[6:0]));
            end
        end
        if (flush) begin
            sb_q.delete();
        end else if (in_valid && in_ready) begin
            sb_q.push_back('{pc: pc_i, instr: instr_i});
            last_accept = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
        in_valid = 1'b1;
        instr_i  = ins;
        pc_i     = pc;
    endtask

    task automatic drain(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 12 && (sb_q.size() != 0 || out_valid); k++) step();
        check(tag, sb_q.size(), 0);
        check({tag, "_idle"}, out_valid, 1'b0);
    endtask

    logic [31:0] tbl [8] = '{32'h00500093, 32'h00208463, 32'h123450B7, 32'h008000EF,
                            32'h002081B3, 32'h00112623, 32'h00001217, 32'h4030D093};

    initial begin
        int idx;
        int budget;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr_i = 32'd0; pc_i = 32'd0;
        #12;
        check("rst_out_valid", out_valid,  1'b0);
        check("rst_in_ready",  in_ready,   1'b1);
        check("rst_imm_type",  imm_type_o, 3'd7);
        check("rst_pc",        pc_o,       TAG);
        check("rst_rd",        rd_o,       5'd0);
        check("rst_imm_in",    imm_in_o,   25'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // addi x1, x0, 5
        out_ready = 1'b1;
        drive(32'h00500093, 32'h0000_0100);
        step();
        in_valid = 1'b0;
        check("addi_valid",    out_valid,  1'b1);
        check("addi_imm_type", imm_type_o, 3'd0);
        check("addi_rd",       rd_o,       5'd1);
        check("addi_rs1",      rs1_o,      5'd0);
        check("addi_imm_in",   imm_in_o,   25'h000A001);
        step();

        // back-to-back beq, lui, jal, add
        drive(32'h00208463, 32'h0000_0200); step();
        check("beq_imm_type", imm_type_o, 3'd1);
        drive(32'h123450B7, 32'h0000_0204); step();
        check("lui_imm_type", imm_type_o, 3'd3);
        check("lui_rd",       rd_o,       5'd1);
        drive(32'h008000EF, 32'h0000_0208); step();
        check("jal_imm_type", imm_type_o, 3'd4);
        drive(32'h002081B3, 32'h0000_020C); step();
        check("add_imm_type", imm_type_o, 3'd7);
        check("add_rs2",      rs2_o,      5'd2);
        drain("b2b_drain");

        // stall: three instructions with out_ready low, only two fit
        out_ready = 1'b0;
        drive(32'h00112623, 32'h0000_0300); step();
        check("stall_ready1", in_ready, 1'b1);
        drive(32'h00001217, 32'h0000_0304); step();
        check("stall_ready2", in_ready, 1'b0);
        drive(32'h00412283, 32'h0000_0308); step();
        check("stall_ready3", in_ready, 1'b0);
        check("stall_sb2",    sb_q.size(), 2);
        out_ready = 1'b1;
        step();                         // main fires, skid moves up
        check("unstall_ready", in_ready, 1'b1);
        check("unstall_pc",    pc_o,     32'h0000_0304);
        step();                         // third instruction accepted here
        in_valid = 1'b0;
        drain("stall_drain");

        // flush with both entries full and a pending accept
        out_ready = 1'b0;
        drive(32'h00500093, 32'h0000_0400); step();
        drive(32'h00208463, 32'h0000_0404); step();
        drive(32'h123450B7, 32'h0000_0408); flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid",    out_valid,  1'b0);
        check("flush_ready",    in_ready,   1'b1);
        check("flush_imm_type", imm_type_o, 3'd7);
        out_ready = 1'b1;
        step(); step();
        check("flush_quiet", out_valid, 1'b0);

        // async reset mid-stall
        out_ready = 1'b0;
        drive(32'h008000EF, 32'h0000_0500); step();
        drive(32'h002081B3, 32'h0000_0504); step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid",    out_valid,  1'b0);
        check("arst_imm_type", imm_type_o, 3'd7);
        check("arst_pc",       pc_o,       TAG);
        check("arst_ready",    in_ready,   1'b1);
        sb_q.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // unrecognised opcodes
        out_ready = 1'b1;
        drive(32'h0000007F, 32'h0000_0600); step();
        in_valid = 1'b0;
        check("ill_imm_type", imm_type_o, 3'd7);
        check("ill_flag",     illegal_o,  ref_illegal(7'h7F));
        drive(32'h00500090, 32'h0000_0604); step();
        in_valid = 1'b0;
`ifdef DECODE_ILLEGAL_DETECT_EN
        check("ill_low_bits", illegal_o, 1'b1);
`else
        check("ill_low_bits", illegal_o, 1'b0);
`endif
        drain("ill_drain");

        // random handshake stream
        idx = 0;
        budget = 0;
        while (idx < 30 && budget < 400) begin
            drive(tbl[idx % 8], 32'h0000_1000 + 32'(idx) * 32'd4);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) in_valid = 1'b0;
            step();
            if (last_accept) idx++;
            budget++;
        end
        check("rand_all_sent", idx, 30);
        drain("rand_drain");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
